// File: rtl/timer_irq.sv
// timer_irq: memory-mapped down-counting timer with one-shot/auto-reload modes and a level interrupt.
// Define TIMER_PRESCALER_EN to build the 16-bit clock prescaler at register offset 4.
module timer_irq #(
    parameter logic [31:0] TICKS_RESET = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        iomem_ready,
    output logic        irq
);

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_LOAD   = 3'd1;
    localparam logic [2:0] OFF_COUNT  = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;

    function automatic logic [31:0] f_lane_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  strb
    );
        logic [31:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    logic        r_en;
    logic        r_auto;
    logic        r_irqen;
    logic        r_exp;
    logic        r_ready;
    logic [31:0] r_load;
    logic [31:0] r_count;
    logic [31:0] r_rdata;

    logic [2:0]  w_sel;
    logic [31:0] w_rd_data;
    logic        w_access;
    logic        w_write;
    logic        w_wr_ctrl;
    logic        w_wr_load;
    logic        w_wr_count;
    logic        w_clr_exp;
    logic        w_pre_term;
    logic        w_tick;
    logic        w_expire;
    logic        w_unused;

    assign w_sel      = iomem_addr[4:2];
    assign w_access   = iomem_valid & ~r_ready;
    assign w_write    = w_access & (|iomem_wstrb);
    assign w_wr_ctrl  = w_write & (w_sel == OFF_CTRL) & iomem_wstrb[0];
    assign w_wr_load  = w_write & (w_sel == OFF_LOAD);
    assign w_wr_count = w_write & (w_sel == OFF_COUNT);
    assign w_clr_exp  = w_write & (w_sel == OFF_STATUS) & iomem_wstrb[0] & iomem_wdata[0];
    assign w_tick     = r_en & w_pre_term;
    assign w_expire   = w_tick & (r_count == 32'd0);
    assign w_unused   = ^{iomem_addr[31:5], iomem_addr[1:0]};

`ifdef TIMER_PRESCALER_EN
    localparam logic [2:0] OFF_PRESCALE = 3'd4;

    logic [15:0] r_prescale;
    logic [15:0] r_pre_cnt;
    logic        w_wr_pre;

    assign w_wr_pre   = w_write & (w_sel == OFF_PRESCALE);
    assign w_pre_term = (r_pre_cnt == r_prescale);

    // Prescaler: counts 0..PRESCALE while enabled, restarts on reconfiguration or disable
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prescale <= 16'd0;
            r_pre_cnt  <= 16'd0;
        end else begin
            if (w_wr_pre) begin
                r_prescale <= {iomem_wstrb[1] ? iomem_wdata[15:8] : r_prescale[15:8],
                               iomem_wstrb[0] ? iomem_wdata[7:0]  : r_prescale[7:0]};
            end
            if (w_wr_pre || !r_en || w_pre_term) begin
                r_pre_cnt <= 16'd0;
            end else begin
                r_pre_cnt <= r_pre_cnt + 16'd1;
            end
        end
    end
`else
    assign w_pre_term = 1'b1;
`endif

    // Register read mux; unmapped offsets return zero
    always_comb begin
        w_rd_data = 32'd0;
        case (w_sel)
            OFF_CTRL:     w_rd_data = {29'd0, r_irqen, r_auto, r_en};
            OFF_LOAD:     w_rd_data = r_load;
            OFF_COUNT:    w_rd_data = r_count;
            OFF_STATUS:   w_rd_data = {31'd0, r_exp};
`ifdef TIMER_PRESCALER_EN
            OFF_PRESCALE: w_rd_data = {16'd0, r_prescale};
`endif
            default:      w_rd_data = 32'd0;
        endcase
    end

    // Bus handshake, register writes and the down-counter; bus writes win over timer events except EXP set
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready <= 1'b0;
            r_rdata <= 32'd0;
            r_en    <= 1'b0;
            r_auto  <= 1'b0;
            r_irqen <= 1'b0;
            r_exp   <= 1'b0;
            r_load  <= TICKS_RESET;
            r_count <= TICKS_RESET;
        end else begin
            r_ready <= w_access;
            r_rdata <= w_access ? w_rd_data : 32'd0;

            if (w_wr_ctrl) begin
                r_en    <= iomem_wdata[0];
                r_auto  <= iomem_wdata[1];
                r_irqen <= iomem_wdata[2];
            end else if (w_expire && !r_auto) begin
                r_en <= 1'b0;
            end

            if (w_wr_load) begin
                r_load <= f_lane_merge(r_load, iomem_wdata, iomem_wstrb);
            end

            if (w_wr_count) begin
                r_count <= f_lane_merge(r_count, iomem_wdata, iomem_wstrb);
            end else if (w_tick) begin
                if (r_count != 32'd0) begin
                    r_count <= r_count - 32'd1;
                end else if (r_auto) begin
                    r_count <= r_load;
                end
            end

            if (w_expire) begin
                r_exp <= 1'b1;
            end else if (w_clr_exp) begin
                r_exp <= 1'b0;
            end
        end
    end

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign irq         = r_exp & r_irqen;

endmodule

// File: doc/timer_irq.md
TIMER_IRQ -- requirements
Module: timer_irq

Interface
REQ-001 SHALL have parameter TICKS_RESET, default 32'd0, giving the LOAD and COUNT reset values.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset; top level drives it with !resetn.
REQ-004 SHALL have port iomem_valid, input, 1, bus request already qualified by the timer address decode at 0x0Axx_xxxx.
REQ-005 SHALL have port iomem_wstrb, input, 4, byte write strobes; 4'b0000 denotes a read.
REQ-006 SHALL have port iomem_addr, input, 32, byte address; only bits [4:2] are decoded.
REQ-007 SHALL have port iomem_wdata, input, 32, write data.
REQ-008 SHALL have port iomem_rdata, output, 32, registered read data.
REQ-009 SHALL have port iomem_ready, output, 1, registered single-cycle transfer acknowledge.
REQ-010 SHALL have port irq, output, 1, level interrupt; top level routes it to picosoc irq_5.

Function
REQ-011 Register map by iomem_addr[4:2]: 0 CTRL {bit0 EN, bit1 AUTO, bit2 IRQEN}, 1 LOAD[31:0], 2 COUNT[31:0], 3 STATUS {bit0 EXP}, 4 PRESCALE[15:0] (see Configuration).
REQ-012 Offsets 5-7 SHALL read 32'h0, ignore writes, and still acknowledge.
REQ-013 Handshake: iomem_ready SHALL go high exactly 1 cycle after iomem_valid is sampled high with iomem_ready low, and SHALL stay high for exactly 1 cycle.
REQ-014 iomem_rdata SHALL be valid in the same cycle as iomem_ready, and SHALL be 0 in all other cycles.
REQ-015 Writes SHALL take effect on the edge that raises iomem_ready; LOAD and COUNT honour each wstrb byte lane; CTRL and STATUS use lane 0 only.
REQ-016 A STATUS write with wdata[0]=1 SHALL clear EXP; writing 0 SHALL have no effect.
REQ-017 tick = EN & prescaler terminal (every cycle when prescaling is absent or PRESCALE=0).
REQ-018 On tick with COUNT!=0: COUNT <= COUNT-1.
REQ-019 On tick with COUNT==0 (expiry): EXP <= 1; if AUTO, COUNT <= LOAD; else EN <= 0 and COUNT stays 0.
REQ-020 Period SHALL be (LOAD+1) ticks in auto-reload mode; COUNT wrap below 0 SHALL never occur.
REQ-021 irq = EXP & IRQEN, combinational from registers, no extra latency.
REQ-022 Simultaneous events: expiry and STATUS clear in the same cycle -> EXP=1 (set wins); COUNT write and tick in the same cycle -> written value wins; CTRL write clearing EN at expiry -> EN=0 and EXP=1.
REQ-023 Enabling with COUNT=0 SHALL expire on the first tick.

Reset
REQ-024 During reset, the following SHALL hold: CTRL=0, EXP=0, LOAD=COUNT=TICKS_RESET, PRESCALE=0, prescaler counter=0, iomem_ready=0, iomem_rdata=0, irq=0.
REQ-025 Reset asserted mid-transfer SHALL drop iomem_ready next edge, discard the pending write, and require the CPU to restart the transfer.

Configuration
REQ-026 Macro TIMER_PRESCALER_EN SHALL control the prescaler.
REQ-027 With TIMER_PRESCALER_EN defined:
- a 16-bit prescaler counter counts 0..PRESCALE while EN is set, then restarts;
- tick occurs at the terminal value, so the tick period is PRESCALE+1 clocks;
- writing PRESCALE or clearing EN zeroes the prescaler counter.
REQ-028 With TIMER_PRESCALER_EN undefined:
- tick = EN every cycle;
- offset 4 behaves as unmapped (reads 0);
- no prescaler flops are synthesised.

Verification
REQ-029 Read after reset: read each offset 0-7 -> CTRL=0, LOAD=COUNT=TICKS_RESET, others 0; each read acks exactly 1 cycle after valid, 1-cycle ready pulse.
REQ-030 One-shot: LOAD=COUNT=5, CTRL=0x5 -> EXP and irq high 6 clocks after enable takes effect; EN reads 0; COUNT stays 0.
REQ-031 Auto-reload: LOAD=3, COUNT=3, CTRL=0x7 -> EXP set every 4 clocks; clear EXP between expiries -> irq pulses re-assert each period.
REQ-032 Race: issue a STATUS write 0x1 that lands on the expiry edge -> EXP reads 1 afterwards.
REQ-033 Byte lanes: COUNT=0xFFFFFFFF, write 0x12345678 with wstrb=4'b0010 -> COUNT=0xFFFF56FF (timer disabled).
REQ-034 Prescaler (macro defined): PRESCALE=2, LOAD=COUNT=1, CTRL=0x7 -> expiry every 6 clocks; macro undefined -> same setup expires every 2 clocks and PRESCALE reads 0.
